// File: rtl/red_seq_pkg.sv
// Shared types and constants for the red_seq nibble-serial reduction unit.
// The result is built from 4-bit partial sums produced by a single shared adder.
package red_seq_pkg;

  localparam int OPERAND_W       = 16;
  localparam int SLICE_W         = 4;
  localparam int RED_SEQ_LATENCY = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    AC_LO = 4'd1,
    AC_HI = 4'd2,
    BD_LO = 4'd3,
    BD_HI = 4'd4,
    R_LO  = 4'd5,
    R_HI  = 4'd6,
    R_TOP = 4'd7,
    DONE  = 4'd8
  } state_t;

  // The 10-bit reduction {top, hi, lo} is sign-extended from its bit 9 (top[1]).
  function automatic logic [OPERAND_W-1:0] pack_result(
    input logic [1:0]         top,
    input logic [SLICE_W-1:0] hi,
    input logic [SLICE_W-1:0] lo
  );
    pack_result = {{6{top[1]}}, top, hi, lo};
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Plain 4-bit adder with carry in and carry out; the only arithmetic in red_seq.
module adder_4bit (
  output logic [3:0] Sum,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic       Cout
);

  // Widen to 5 bits so the carry lands in the top bit.
  always_comb begin
    {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
  end

endmodule

// File: rtl/red_seq.sv
// Sequential 16-bit reduction: Sum = sext10((In1[15:8]+In2[15:8]) + (In1[7:0]+In2[7:0])),
// computed one nibble per cycle through a single time-shared 4-bit adder.
module red_seq
  import red_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] In1,
  input  logic [15:0] In2,
  output logic [15:0] Sum,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [3:0]  ac_lo;
  logic [3:0]  ac_hi;
  logic [3:0]  bd_lo;
  logic [3:0]  bd_hi;
  logic [3:0]  r_lo;
  logic [3:0]  r_hi;
  logic        ac_c;
  logic        bd_c;
  logic        carry;

  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  adder_4bit u_add (
    .Sum  (add_sum),
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .Cout (add_cout)
  );

  // Steer the shared adder's operands from the current state.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state)
      AC_LO: begin
        add_a   = op1[11:8];
        add_b   = op2[11:8];
        add_cin = 1'b0;
      end
      AC_HI: begin
        add_a   = op1[15:12];
        add_b   = op2[15:12];
        add_cin = carry;
      end
      BD_LO: begin
        add_a   = op1[3:0];
        add_b   = op2[3:0];
        add_cin = 1'b0;
      end
      BD_HI: begin
        add_a   = op1[7:4];
        add_b   = op2[7:4];
        add_cin = carry;
      end
      R_LO: begin
        add_a   = ac_lo;
        add_b   = bd_lo;
        add_cin = 1'b0;
      end
      R_HI: begin
        add_a   = ac_hi;
        add_b   = bd_hi;
        add_cin = carry;
      end
      R_TOP: begin
        add_a   = {3'b000, ac_c};
        add_b   = {3'b000, bd_c};
        add_cin = carry;
      end
      default: begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Sequencer and all datapath storage; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op1   <= 16'h0000;
      op2   <= 16'h0000;
      ac_lo <= 4'h0;
      ac_hi <= 4'h0;
      bd_lo <= 4'h0;
      bd_hi <= 4'h0;
      r_lo  <= 4'h0;
      r_hi  <= 4'h0;
      ac_c  <= 1'b0;
      bd_c  <= 1'b0;
      carry <= 1'b0;
      Sum   <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op1   <= In1;
            op2   <= In2;
            busy  <= 1'b1;
            state <= AC_LO;
          end
        end
        AC_LO: begin
          ac_lo <= add_sum;
          carry <= add_cout;
          state <= AC_HI;
        end
        AC_HI: begin
          ac_hi <= add_sum;
          ac_c  <= add_cout;
          state <= BD_LO;
        end
        BD_LO: begin
          bd_lo <= add_sum;
          carry <= add_cout;
          state <= BD_HI;
        end
        BD_HI: begin
          bd_hi <= add_sum;
          bd_c  <= add_cout;
          state <= R_LO;
        end
        R_LO: begin
          r_lo  <= add_sum;
          carry <= add_cout;
          state <= R_HI;
        end
        R_HI: begin
          r_hi  <= add_sum;
          carry <= add_cout;
          state <= R_TOP;
        end
        R_TOP: begin
          // Top sum is at most 3, so only two bits matter and the carry out is dropped.
          Sum   <= pack_result(add_sum[1:0], r_hi, r_lo);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
